// File: rtl/rd_arb_pkg.sv
// Shared types and helpers for the parametrised multichannel read arbiter.
package rd_arb_pkg;

    // Arbiter FSM: waiting for a request, or a burst is outstanding on the AXI master
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Next round-robin start index after idx, wrapping at n (n need not be a power of two)
    function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] n);
        logic [31:0] nxt;
        nxt = idx + 32'd1;
        if (nxt >= n) begin
            return 32'd0;
        end else begin
            return nxt;
        end
    endfunction

endpackage

// File: rtl/multichannel_rd_arbiter_param_rr_prio_pick.sv
// Combinational winner search: the first requesting channel at or after ptr,
// wrapping modulo CH_NUM. With ptr held at 0 this is plain fixed priority.
module rr_prio_pick #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_NUM-1:0] grant,
    output logic [CH_W-1:0]   win,
    output logic              any_req
);

    localparam int SUM_W = CH_W + 1;

    logic [CH_NUM-1:0] rot_s;
    logic [CH_W-1:0]   off_s;
    logic [SUM_W-1:0]  raw_s;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then map back to a channel index
    always_comb begin
        grant   = {CH_NUM{1'b0}};
        rot_s   = CH_NUM'({req, req} >> ptr);
        off_s   = {CH_W{1'b0}};
        for (int j = CH_NUM - 1; j >= 0; j--) begin
            off_s = rot_s[j] ? CH_W'(j) : off_s;
        end
        raw_s   = {1'b0, ptr} + {1'b0, off_s};
        win     = CH_W'((raw_s >= SUM_W'(CH_NUM)) ? (raw_s - SUM_W'(CH_NUM)) : raw_s);
        any_req = |req;
        for (int i = 0; i < CH_NUM; i++) begin
            grant[i] = any_req && (win == CH_W'(i));
        end
    end

endmodule

// File: rtl/multichannel_rd_arbiter_param.sv
// N-channel read arbiter in front of the single AXI read master. Grants one
// channel at a time, latches its address/length/ID, and optionally aborts a
// burst that stays outstanding for too long.
module multichannel_rd_arbiter_param
    import rd_arb_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int CH_W        = 2,
    parameter int ADDR_WIDTH  = 30,
    parameter int LEN_WIDTH   = 8,
    parameter int RR_EN       = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH_NUM-1:0]            rd_req,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] rd_addr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]  rd_len,
    output logic [CH_NUM-1:0]            rd_grant,
    input  logic                         rd_done,
    output logic                         axi_rd_start,
    output logic [ADDR_WIDTH-1:0]        axi_rd_addr,
    output logic [LEN_WIDTH-1:0]         axi_rd_len,
    output logic [CH_W-1:0]              axi_rd_ch,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam bit              WD_EN   = (TIMEOUT_CYC > 0);

    arb_state_t              state_r;
    arb_state_t              state_s;
    logic [CH_W-1:0]         ptr_r;
    logic [CH_W-1:0]         ptr_nxt_s;
    logic [CH_W-1:0]         win_s;
    logic [CH_NUM-1:0]       grant_s;
    logic                    any_req_s;
    logic                    grant_now_s;
    logic                    timeout_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic [LEN_WIDTH-1:0]    len_s;
    logic [WD_W-1:0]         wdog_r;

    logic [CH_NUM-1:0]       rd_grant_r;
    logic                    start_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [LEN_WIDTH-1:0]    len_r;
    logic [CH_W-1:0]         ch_r;
    logic                    busy_r;
    logic                    terr_r;

    rr_prio_pick #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_pick (
        .req     (rd_req),
        .ptr     (ptr_r),
        .grant   (grant_s),
        .win     (win_s),
        .any_req (any_req_s)
    );

    // Fixed-priority mode keeps the search anchored at channel 0
    assign ptr_nxt_s = (RR_EN != 0) ? CH_W'(wrap_inc(32'(win_s), 32'(CH_NUM))) : {CH_W{1'b0}};

    // Select the winner's address and length from the flattened buses (one-hot AND-OR)
    always_comb begin
        addr_s = {ADDR_WIDTH{1'b0}};
        len_s  = {LEN_WIDTH{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            addr_s = addr_s | (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_s[i]}});
            len_s  = len_s  | (rd_len[i*LEN_WIDTH +: LEN_WIDTH]    & {LEN_WIDTH{grant_s[i]}});
        end
    end

    // Next state, grant qualifier and watchdog expiry; rd_done beats a same-cycle timeout
    always_comb begin
        state_s     = state_r;
        grant_now_s = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s     = BUSY;
                    grant_now_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (rd_done) begin
                    state_s = IDLE;
                end else if (WD_EN && (wdog_r == WD_LAST)) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pointer, watchdog counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r      <= {CH_W{1'b0}};
            wdog_r     <= {WD_W{1'b0}};
            rd_grant_r <= {CH_NUM{1'b0}};
            start_r    <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            len_r      <= {LEN_WIDTH{1'b0}};
            ch_r       <= {CH_W{1'b0}};
            busy_r     <= 1'b0;
            terr_r     <= 1'b0;
        end else begin
            rd_grant_r <= {CH_NUM{1'b0}};
            start_r    <= 1'b0;
            terr_r     <= 1'b0;
            if (grant_now_s) begin
                rd_grant_r <= grant_s;
                start_r    <= 1'b1;
                addr_r     <= addr_s;
                len_r      <= len_s;
                ch_r       <= win_s;
                busy_r     <= 1'b1;
                ptr_r      <= ptr_nxt_s;
                wdog_r     <= {WD_W{1'b0}};
            end else if (state_r == BUSY) begin
                if (rd_done || timeout_s) begin
                    busy_r <= 1'b0;
                    terr_r <= timeout_s;
                end else begin
                    wdog_r <= wdog_r + WD_W'(1);
                end
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign rd_grant     = rd_grant_r;
    assign axi_rd_start = start_r;
    assign axi_rd_addr  = addr_r;
    assign axi_rd_len   = len_r;
    assign axi_rd_ch    = ch_r;
    assign busy         = busy_r;
    assign timeout_err  = terr_r;

endmodule
